// File: rtl/uart_tx_ctrl_if.sv
// Handshake bundle between the UART TX burst controller and its environment:
// burst command, RAM read port, UART transmitter port and burst status.
// The controller connects through the slave modport; whatever drives bursts,
// models the RAM and the transmitter uses the master modport.
interface uart_tx_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   byte_len;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rd_data;
  logic              tx_ready;
  logic [7:0]        tx_data_o;
  logic              tx_idle;
  logic              tx_bits_ok;
  logic              bps_clk_up;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   sent_cnt;

  modport slave (
    input  start, abort, base_addr, byte_len, ram_rd_data,
           tx_idle, tx_bits_ok, bps_clk_up,
    output ram_rd_en, ram_addr, tx_ready, tx_data_o, busy, done, sent_cnt
  );

  modport master (
    output start, abort, base_addr, byte_len, ram_rd_data,
           tx_idle, tx_bits_ok, bps_clk_up,
    input  ram_rd_en, ram_addr, tx_ready, tx_data_o, busy, done, sent_cnt
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX burst controller: reads byte_len bytes from RAM starting at
// base_addr and hands them one at a time to a UART transmitter, counting
// completed frames. An abort ends the burst after the frame in progress.
// Optional feature: define UART_TX_CTRL_GAP_EN to insert GAP_BITS bit-times
// of idle line between consecutive bytes of a burst.
module uart_tx_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int GAP_BITS = 3
) (
  input  logic          sys_clk,
  input  logic          rst,
  uart_tx_ctrl_if.slave bus
);

`ifdef UART_TX_CTRL_GAP_EN
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, WAIT_END, FINISH, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, WAIT_END, FINISH} state_t;
`endif

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   sent;
  logic [ADDR_W:0]   sent_inc;
  logic [7:0]        data;
  logic              busy_r;
  logic              done_r;
  logic              abort_pend;
  logic              stop_now;

`ifdef UART_TX_CTRL_GAP_EN
  logic [3:0]        gap_cnt;
`endif

  // A same-cycle abort counts as pending so the decision after a frame sees it.
  assign sent_inc = sent + (ADDR_W+1)'(1);
  assign stop_now = (sent_inc == len) || abort_pend || bus.abort;

  // Next-state logic; start/abort only matter in the states listed.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.start) state_nx = (bus.byte_len == '0) ? FINISH : FETCH;
      end
      FETCH:    state_nx = LATCH;
      LATCH:    state_nx = SEND;
      SEND: begin
        if (!bus.tx_idle) state_nx = WAIT_END;
      end
      WAIT_END: begin
        if (bus.tx_bits_ok) begin
          if (stop_now) state_nx = FINISH;
`ifdef UART_TX_CTRL_GAP_EN
          else          state_nx = GAP;
`else
          else          state_nx = FETCH;
`endif
        end
      end
`ifdef UART_TX_CTRL_GAP_EN
      GAP: begin
        if (abort_pend || bus.abort)                               state_nx = FINISH;
        else if (bus.bps_clk_up && gap_cnt == 4'(GAP_BITS - 1))    state_nx = FETCH;
      end
`endif
      FINISH:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Burst bookkeeping: address/length capture, byte latch, frame count, abort flag.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      addr       <= '0;
      len        <= '0;
      sent       <= '0;
      data       <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      done_r <= (state == FINISH);
      if (state == IDLE && bus.start) begin
        addr   <= bus.base_addr;
        len    <= bus.byte_len;
        sent   <= '0;
        busy_r <= 1'b1;
      end
      if (state == LATCH) data <= bus.ram_rd_data;
      if (state == WAIT_END && bus.tx_bits_ok) begin
        sent <= sent_inc;
        addr <= addr + ADDR_W'(1);
      end
      if (state == FINISH) begin
        busy_r     <= 1'b0;
        abort_pend <= 1'b0;
      end else if (state != IDLE && bus.abort) begin
        abort_pend <= 1'b1;
      end
    end
  end

`ifdef UART_TX_CTRL_GAP_EN
  // Bit-time counter, only running while the line is held idle between bytes.
  always_ff @(posedge sys_clk) begin
    if (rst || state != GAP) gap_cnt <= '0;
    else if (bus.bps_clk_up) gap_cnt <= gap_cnt + 4'd1;
  end
`endif

  // Strobes decode straight from state; everything else is registered.
  always_comb begin
    bus.ram_rd_en = (state == FETCH);
    bus.ram_addr  = addr;
    bus.tx_ready  = (state == SEND);
    bus.tx_data_o = data;
    bus.busy      = busy_r;
    bus.done      = done_r;
    bus.sent_cnt  = sent;
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: RAM and UART transmitter models around the DUT,
// a table of directed bursts, randomized bursts, and hand-written sequences
// for reset, latency, zero-length, inter-byte gap and reset mid-frame.
module tb_uart_tx_ctrl;
  localparam int ADDR_W   = 8;
  localparam int GAP_BITS = 3;

  logic sys_clk = 1'b0;
  logic rst;
  always #5 sys_clk = ~sys_clk;

  uart_tx_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_ctrl #(.ADDR_W(ADDR_W), .GAP_BITS(GAP_BITS)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // RAM model: data valid exactly one cycle after the read strobe, junk otherwise.
  logic [7:0] mem [256];
  logic [7:0] ram_q = 8'h00;
  int         rd_seen = 0;
  logic [7:0] addr_q [$];
  always @(posedge sys_clk) begin
    if (bus.ram_rd_en) begin
      ram_q   <= mem[bus.ram_addr];
      rd_seen <= rd_seen + 1;
      addr_q.push_back(bus.ram_addr);
    end else begin
      ram_q <= 8'($urandom);
    end
  end
  assign bus.ram_rd_data = ram_q;

  // Transmitter model: accepts a byte when idle and requested, busy for a
  // random frame time, then pulses bits_ok.
  logic       tx_active = 1'b0;
  logic       tx_ok     = 1'b0;
  int         tx_left   = 0;
  int         accepted  = 0;
  logic [7:0] cap_q [$];
  always @(posedge sys_clk) begin
    tx_ok <= 1'b0;
    if (tx_active) begin
      if (tx_left <= 1) begin
        tx_active <= 1'b0;
        tx_ok     <= 1'b1;
      end else begin
        tx_left <= tx_left - 1;
      end
    end else if (bus.tx_ready) begin
      tx_active <= 1'b1;
      tx_left   <= 4 + $urandom_range(0, 5);
      accepted  <= accepted + 1;
      cap_q.push_back(bus.tx_data_o);
    end
  end
  assign bus.tx_idle    = !tx_active;
  assign bus.tx_bits_ok = tx_ok;

  // Bit-rate tick every 4 cycles.
  logic [1:0] tick_div = 2'd0;
  logic       tick     = 1'b0;
  always @(posedge sys_clk) begin
    tick_div <= tick_div + 2'd1;
    tick     <= (tick_div == 2'd3);
  end
  assign bus.bps_clk_up = tick;

  int done_cnt = 0;
  always @(posedge sys_clk) if (bus.done) done_cnt <= done_cnt + 1;

  task automatic wait_tx_idle();
    for (int i = 0; i < 100 && !bus.tx_idle; i++) @(negedge sys_clk);
  endtask

  task automatic wait_done(input string tag, input int exp_sent);
    bit got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      if (bus.done) got = 1'b1;
      else @(negedge sys_clk);
    end
    check({tag, "_done_seen"}, int'(got), 1);
    check({tag, "_sent_cnt"}, int'(bus.sent_cnt), exp_sent);
    @(negedge sys_clk);
  endtask

  // Burst runner. amode: 0 none, 1 abort after the read of byte aidx,
  // 2 abort while frame aidx is in flight, 3 abort coinciding with start.
  task automatic run_burst(input string tag, input logic [7:0] base, input int len,
                           input int amode, input int aidx, input bit sbusy,
                           input int exp_sent);
    int cap0, addr0, rd0, acc0, done0, nb;
    bit fired, sfired, got;
    wait_tx_idle();
    cap0 = cap_q.size(); addr0 = addr_q.size();
    rd0 = rd_seen; acc0 = accepted; done0 = done_cnt;
    bus.base_addr = base;
    bus.byte_len  = 9'(len);
    bus.start     = 1'b1;
    bus.abort     = (amode == 3);
    @(negedge sys_clk);
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.base_addr = ~base;
    bus.byte_len  = 9'(len + 3);
    fired = 1'b0; sfired = 1'b0; got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      if (bus.done) begin
        got = 1'b1;
        check({tag, "_sent_cnt"}, int'(bus.sent_cnt), exp_sent);
        check({tag, "_busy_at_done"}, int'(bus.busy), 0);
      end else begin
        bus.abort = 1'b0;
        bus.start = 1'b0;
        if (amode == 1 && !fired && rd_seen - rd0 == aidx + 1) begin
          bus.abort = 1'b1; fired = 1'b1;
        end
        if (amode == 2 && !fired && accepted - acc0 == aidx + 1) begin
          bus.abort = 1'b1; fired = 1'b1;
        end
        if (sbusy && !sfired && accepted - acc0 == 1) begin
          bus.start = 1'b1; sfired = 1'b1;
        end
        @(negedge sys_clk);
      end
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check({tag, "_done_seen"}, int'(got), 1);
    repeat (6) @(negedge sys_clk);
    check({tag, "_done_pulses"}, done_cnt - done0, 1);
    check({tag, "_bytes_sent"}, cap_q.size() - cap0, exp_sent);
    check({tag, "_ram_reads"}, addr_q.size() - addr0, exp_sent);
    nb = cap_q.size() - cap0;
    if (nb > exp_sent) nb = exp_sent;
    for (int i = 0; i < nb; i++) begin
      check({tag, "_byte"}, int'(cap_q[cap0 + i]), int'(mem[8'(base + 8'(i))]));
      check({tag, "_addr"}, int'(addr_q[addr0 + i]), int'(8'(base + 8'(i))));
    end
  endtask

  typedef struct {
    logic [7:0] base;
    int         len;
    int         amode;
    int         aidx;
    bit         sbusy;
    int         exp_sent;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ticks, cyc, len, amode, aidx, exp_sent;
    bit saw, found;
    logic [7:0] base;

    vecs[0] = '{8'h10, 4, 0, 0, 1'b0, 4};
    vecs[1] = '{8'hFE, 3, 0, 0, 1'b0, 3};
    vecs[2] = '{8'h20, 5, 2, 1, 1'b1, 2};
    vecs[3] = '{8'h30, 5, 1, 2, 1'b0, 3};
    vecs[4] = '{8'h40, 1, 0, 0, 1'b0, 1};
    vecs[5] = '{8'hF0, 0, 0, 0, 1'b0, 0};
    vecs[6] = '{8'h80, 3, 3, 0, 1'b0, 3};

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h6E; mem[8'h11] = 8'hF0; mem[8'h12] = 8'h0F; mem[8'h13] = 8'hA5;

    bus.start = 1'b0; bus.abort = 1'b0; bus.base_addr = '0; bus.byte_len = '0;
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_tx_ready",  int'(bus.tx_ready),  0);
    check("rst_ram_rd_en", int'(bus.ram_rd_en), 0);
    check("rst_busy",      int'(bus.busy),      0);
    check("rst_done",      int'(bus.done),      0);
    check("rst_tx_data",   int'(bus.tx_data_o), 0);
    check("rst_ram_addr",  int'(bus.ram_addr),  0);
    check("rst_sent_cnt",  int'(bus.sent_cnt),  0);
    rst = 1'b0;
    @(negedge sys_clk);

    // Abort while idle must be ignored by the next burst.
    bus.abort = 1'b1;
    @(negedge sys_clk);
    bus.abort = 1'b0;
    @(negedge sys_clk);

    for (int v = 0; v < 7; v++)
      run_burst($sformatf("vec%0d", v), vecs[v].base, vecs[v].len, vecs[v].amode,
                vecs[v].aidx, vecs[v].sbusy, vecs[v].exp_sent);

    // Start to first tx_ready latency, with the fetch cycle in between.
    wait_tx_idle();
    bus.base_addr = 8'h50; bus.byte_len = 9'd1; bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    check("fetch_rd_en", int'(bus.ram_rd_en), 1);
    check("fetch_addr",  int'(bus.ram_addr),  'h50);
    check("busy_on",     int'(bus.busy),      1);
    lat = 1;
    for (int i = 0; i < 20 && !bus.tx_ready; i++) begin
      @(negedge sys_clk);
      lat++;
    end
    check("start_to_tx_ready", lat, 3);
    check("latched_byte", int'(bus.tx_data_o), int'(mem[8'h50]));
    wait_done("lat", 1);

    // Zero-length burst: done two cycles after start, no strobes.
    wait_tx_idle();
    bus.base_addr = 8'h33; bus.byte_len = 9'd0; bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    saw = 1'b0;
    lat = 1;
    for (int i = 0; i < 20 && !bus.done; i++) begin
      if (bus.ram_rd_en || bus.tx_ready) saw = 1'b1;
      @(negedge sys_clk);
      lat++;
    end
    check("zero_len_done_latency", lat, 2);
    check("zero_len_no_strobes", int'(saw), 0);
    check("zero_len_sent_cnt", int'(bus.sent_cnt), 0);
    @(negedge sys_clk);

    // Inter-byte spacing between end of frame and the next RAM read.
    wait_tx_idle();
    bus.base_addr = 8'h60; bus.byte_len = 9'd2; bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (bus.tx_bits_ok) found = 1'b1;
      else @(negedge sys_clk);
    end
    check("gap_first_bits_ok", int'(found), 1);
    ticks = 0;
    @(negedge sys_clk);
    cyc = 1;
    for (int i = 0; i < 200 && !bus.ram_rd_en; i++) begin
      if (bus.bps_clk_up) ticks++;
      @(negedge sys_clk);
      cyc++;
    end
`ifdef UART_TX_CTRL_GAP_EN
    check("gap_ticks_before_fetch", ticks, GAP_BITS);
`else
    check("gap_cycles_to_fetch", cyc, 1);
`endif
    wait_done("gap", 2);

    // Reset while waiting for end of frame, then a clean burst.
    wait_tx_idle();
    bus.base_addr = 8'h70; bus.byte_len = 9'd3; bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (bus.busy && !bus.tx_ready && !bus.tx_idle) found = 1'b1;
      else @(negedge sys_clk);
    end
    check("reached_wait_end", int'(found), 1);
    rst = 1'b1;
    @(negedge sys_clk);
    check("midrst_tx_ready",  int'(bus.tx_ready),  0);
    check("midrst_ram_rd_en", int'(bus.ram_rd_en), 0);
    check("midrst_busy",      int'(bus.busy),      0);
    check("midrst_done",      int'(bus.done),      0);
    check("midrst_tx_data",   int'(bus.tx_data_o), 0);
    check("midrst_ram_addr",  int'(bus.ram_addr),  0);
    check("midrst_sent_cnt",  int'(bus.sent_cnt),  0);
    rst = 1'b0;
    @(negedge sys_clk);
    run_burst("after_rst", 8'h90, 3, 0, 0, 1'b0, 3);

    // Randomized bursts against the reference rules.
    for (int r = 0; r < 20; r++) begin
      base  = 8'($urandom);
      len   = $urandom_range(0, 6);
      amode = (len > 0) ? $urandom_range(0, 3) : 0;
      aidx  = (len > 0) ? $urandom_range(0, len - 1) : 0;
      for (int k = 0; k < len; k++) mem[8'(base + 8'(k))] = 8'($urandom);
      exp_sent = (amode == 1 || amode == 2) ? aidx + 1 : len;
      run_burst($sformatf("rnd%0d", r), base, len, amode, aidx,
                1'($urandom_range(0, 1)), exp_sent);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width.
REQ-002 Parameter GAP_BITS, default 3, idle bit-times inserted between bytes when the gap feature is compiled in (1..15).
REQ-003 sys_clk  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse, begins a burst.
REQ-006 abort  input  1  one-cycle pulse, ends the burst after the current frame.
REQ-007 base_addr  input  ADDR_W  first RAM address of the burst.
REQ-008 byte_len  input  ADDR_W+1  number of bytes to send, 0..2^ADDR_W.
REQ-009 ram_rd_en  output  1  RAM read strobe.
REQ-010 ram_addr  output  ADDR_W  RAM read address.
REQ-011 ram_rd_data  input  8  RAM data, valid exactly 1 cycle after ram_rd_en.
REQ-012 tx_ready  output  1  request to the UART transmitter.
REQ-013 tx_data_o  output  8  byte to the UART transmitter.
REQ-014 tx_idle  input  1  transmitter idle flag (low while a frame is in flight).
REQ-015 tx_bits_ok  input  1  one-cycle pulse at end of frame (after stop bit).
REQ-016 bps_clk_up  input  1  one-cycle bit-rate tick.
REQ-017 busy  output  1  high from burst acceptance until done.
REQ-018 done  output  1  one-cycle pulse at burst end.
REQ-019 sent_cnt  output  ADDR_W+1  bytes fully transmitted in the current or last burst.

Function
REQ-020 FSM states: IDLE, FETCH, LATCH, SEND, WAIT_END, GAP, FINISH.
REQ-021 IDLE: start=1 with byte_len>0 -> latch base_addr/byte_len, clear sent_cnt, busy=1, go FETCH; with byte_len=0 -> go FINISH with no RAM read.
REQ-022 start while busy is ignored; base_addr/byte_len are sampled only on an accepted start.
REQ-023 FETCH: ram_rd_en=1 for exactly one cycle with the current address -> LATCH.
REQ-024 LATCH: tx_data_o <= ram_rd_data -> SEND; tx_data_o is held stable until the next LATCH.
REQ-025 SEND: tx_ready=1 until the cycle tx_idle is sampled low, then tx_ready=0 next cycle -> WAIT_END; tx_bits_ok is ignored in SEND.
REQ-026 WAIT_END: on tx_bits_ok, sent_cnt increments and the address increments modulo 2^ADDR_W (wrap 0xFF -> 0x00 for ADDR_W=8).
REQ-027 After the increment: if sent_cnt equals byte_len or an abort is pending -> FINISH, else GAP (when compiled in) or FETCH.
REQ-028 An abort pulse in any non-IDLE state is latched as pending; abort in IDLE is ignored; abort never truncates a frame already requested.
REQ-029 An abort in FETCH or LATCH sends that byte; if start and abort coincide in IDLE, start wins and abort is ignored.
REQ-030 FINISH: done=1 for one cycle, busy=0, pending abort cleared -> IDLE.
REQ-031 Latency from start to first tx_ready = 3 cycles (FETCH, LATCH, SEND entry).

Reset
REQ-032 rst=1 on a clock edge forces IDLE; tx_ready, ram_rd_en, busy, done and abort-pending go to 0; tx_data_o, ram_addr and sent_cnt go to 0.
REQ-033 Reset mid-frame drops tx_ready immediately and does not wait for tx_bits_ok; the frame already in the transmitter is not tracked.

Configuration
REQ-034 Macro UART_TX_CTRL_GAP_EN defined: GAP state counts GAP_BITS bps_clk_up ticks after each non-final byte, then goes FETCH.
REQ-035 UART_TX_CTRL_GAP_EN undefined: no GAP state and no gap counter; WAIT_END goes directly to FETCH, giving back-to-back frames.

Verification
REQ-036 base_addr=0x10, byte_len=4, RAM[0x10..0x13]=0x6E,0xF0,0x0F,0xA5 -> the four bytes appear on tx_data_o in order, sent_cnt=4, and one done pulse occurs.
REQ-037 base_addr=0xFE, byte_len=3 -> ram_addr sequence is 0xFE, 0xFF, 0x00.
REQ-038 byte_len=0 -> done pulses 2 cycles after start, with no ram_rd_en and no tx_ready.
REQ-039 abort during the 2nd of 5 bytes -> the 2nd frame completes, sent_cnt=2, and done follows; a start issued while busy has no effect.
REQ-040 GAP_BITS=3 with the macro defined -> exactly 3 bps_clk_up ticks between tx_bits_ok and the next ram_rd_en; with the macro undefined -> ram_rd_en follows 1 cycle after tx_bits_ok.
REQ-041 rst asserted while in WAIT_END -> all outputs read 0 the next cycle; a following start runs a clean burst.
